// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor D = A - B with start/done handshake
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 difference bits produced so far, MSB-aligned.
    logic [WIDTH-2:0] d_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             borrow_next;
    logic             last_shift;
    logic [WIDTH-1:0] d_final;

    // Single full-subtractor cell working on the current LSBs.
    always_comb begin
        a_bit       = a_sr[0];
        b_bit       = b_sr[0];
        d_bit       = a_bit ^ b_bit ^ borrow;
        borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
        d_final     = {d_bit, d_sr};
        last_shift  = (cnt == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Operand capture, serial shifting and result registration on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            Bo     <= 1'b0;
            Z      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        d_sr   <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    d_sr   <= d_final[WIDTH-1:1];
                    borrow <= borrow_next;
                    cnt    <= cnt + 1'b1;
                    if (last_shift) begin
                        D  <= d_final;
                        Bo <= borrow_next;
                        Z  <= (d_final == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             Z;
    logic             busy;
    logic             done;

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(WIDTH), .CW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .D     (D),
        .Bo    (Bo),
        .Z     (Z),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int ref_d(input int a, input int b);
        return (a - b + (1 << WIDTH)) % (1 << WIDTH);
    endfunction

    function automatic int ref_bo(input int a, input int b);
        return (a < b) ? 1 : 0;
    endfunction

    function automatic int ref_z(input int a, input int b);
        return (a == b) ? 1 : 0;
    endfunction

    task automatic run_op(input int a, input int b, input string tag);
        int lat;
        int busy_cycles;
        bit got;
        A = WIDTH'(a);
        B = WIDTH'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
            if (done) got = 1;
        end
        if (busy) busy_cycles++;
        check({tag, "_done_seen"}, int'(got), 1);
        check({tag, "_latency"}, lat, WIDTH);
        check({tag, "_D"}, int'(D), ref_d(a, b));
        check({tag, "_Bo"}, int'(Bo), ref_bo(a, b));
        check({tag, "_Z"}, int'(Z), ref_z(a, b));
        tick();
        check({tag, "_busy_cycles"}, busy_cycles, WIDTH + 1);
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        int pulses;
        int cyc;
        int last;
        int ra;
        int rb;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_D", int'(D), 0);
        check("reset_Bo", int'(Bo), 0);
        check("reset_Z", int'(Z), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        run_op(9, 4, "sub_9_4");
        run_op(3, 5, "sub_3_5");
        run_op(0, 1, "sub_0_1");
        run_op(0, 0, "sub_0_0");
        run_op(15, 15, "sub_15_15");
        run_op(15, 0, "sub_15_0");

        // Start pulse while busy must be ignored.
        A = 4'd7;
        B = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        A = 4'd1;
        B = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = 4'd0;
        B = 4'd0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    check("busy_start_D", int'(D), 5);
                    check("busy_start_Bo", int'(Bo), 0);
                end
            end
            tick();
        end
        check("busy_start_pulses", pulses, 1);
        check("busy_start_hold_D", int'(D), 5);

        // Reset in the second SHIFT cycle discards the operation.
        A = 4'd12;
        B = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_D", int'(D), 0);
        check("midrst_Bo", int'(Bo), 0);
        check("midrst_Z", int'(Z), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        run_op(12, 3, "after_rst");

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            ra = int'($urandom_range(0, (1 << WIDTH) - 1));
            rb = int'($urandom_range(0, (1 << WIDTH) - 1));
            run_op(ra, rb, "random");
        end

        // Held start gives back-to-back operations every WIDTH+2 cycles.
        A = 4'd10;
        B = 4'd6;
        start = 1'b1;
        cyc = 0;
        last = -1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            cyc++;
            if (pulses > 0) check("held_D_stable", int'(D), 4);
            if (done) begin
                check("held_D", int'(D), 4);
                if (last >= 0) check("held_period", cyc - last, WIDTH + 2);
                last = cyc;
                pulses++;
            end
        end
        check("held_pulses", pulses, 5);
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("final_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
